spawn_scheduler: RTL and testbench
==================================

# spawn_scheduler

Parametrised successor to the per-class queue logic inside the horizon controller. It owns one circular ring of entity slots (clouds, obstacles or any future scrolling class) and sequences one update pulse per frame tick. On each tick it decides whether to spawn a new entity, picking its type under duplicate and minimum-speed limits, then retires every expired entity at the front of the ring. One instance sits per entity class under the horizon level; the slot modules (cloud, obstacle, ...) stay outside and report back through the feedback ports.

## Interface
Parameters:
- `SLOTS`, 7: ring depth, 2..16.
- `IDX_W`, `$clog2(SLOTS)`: derived, not overridden.
- `TYPE_COUNT`, 3: spawnable types 1..`TYPE_COUNT`; 0 = NONE.
- `TYPE_W`, 3: type field width, must satisfy `TYPE_COUNT` < 2^`TYPE_W`.
- `MAX_DUP`, 2: maximum consecutive identical types, 1..`SLOTS`.
- `GAME_WIDTH`, 640: spawn threshold in pixels.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: leave WAIT.
- `crash` in 1: freeze.
- `tick` in 1: frame update request, one-cycle pulse.
- `enable` in 1: spawning permitted.
- `rng` in 11: random word, sampled in SPAWN.
- `speed` in 15: current speed.
- `min_speed` in [TYPE_COUNT+1][15]: minimum speed per type; index 0 ignored.
- `slot_x` in [SLOTS] signed 11: slot x position.
- `slot_width` in [SLOTS] 10: slot width.
- `slot_gap` in [SLOTS] 11: slot gap.
- `slot_visible` in [SLOTS] 1: slot visible.
- `slot_remove` in [SLOTS] 1: slot expired.
- `slot_start` out [SLOTS] 1: slot active.
- `slot_type` out [SLOTS] TYPE_W: slot type.
- `slot_update` out 1: one-cycle advance strobe to all slots.
- `front` out IDX_W: oldest slot index.
- `count` out IDX_W+1: occupied slots.
- `busy` out 1: high outside WAIT/RUN/CRASHED.
- `overrun` out 1: sticky; a tick arrived while busy.
- `full_drop` out 1: one-cycle pulse; spawn was due but the ring was full.

## Operation
- States: WAIT, RUN, SPAWN, SETTLE, REMOVE, CRASHED.
- WAIT -> RUN on `start`.
- RUN -> SPAWN on `tick`.
- SPAWN -> SETTLE -> REMOVE.
- REMOVE stays while `count`>0 and `slot_remove[front]`, retiring one entity per cycle; otherwise -> RUN.
- `crash` in any state except WAIT -> CRASHED at the next edge. CRASHED exits only via `rst_n`.
- SPAWN: `slot_update`=1.
  - Spawn is due if `enable` and either `count`==0, or `slot_visible[last]` and `slot_x[last]+slot_width[last]+slot_gap[last]` < `GAME_WIDTH`.
  - `last` = (`front`+`count`-1) mod `SLOTS`.
  - Evaluate the sum in 13-bit signed; zero-extend the unsigned operands.
- Type pick: for i=0..`TYPE_COUNT`-1, candidate = ((`rng`+i) mod `TYPE_COUNT`)+1.
  - Accept the first candidate with `speed` >= `min_speed[cand]` whose type does not occupy all of the newest `MAX_DUP` occupied slots.
  - If fewer than `MAX_DUP` slots are occupied, there is no duplicate restriction.
  - If no candidate qualifies, no spawn happens that tick.
- Spawn write at the end of SPAWN, to slot index `back` = (`front`+`count`) mod `SLOTS`:
  - `slot_start[back]`<=1, `slot_type[back]`<=type, `count`++.
- Due but `count`==`SLOTS`: no write; `full_drop` pulses.
- Retire: `slot_start[front]`<=0, `slot_type[front]`<=0, `front`<=`front`+1 mod `SLOTS`, `count`--.
- Indices wrap at `SLOTS`, not at 2^IDX_W.

## Timing
- Reset value of all outputs: 0. State = WAIT.
- `tick` -> `slot_update` high the next cycle, for exactly one cycle.
- Slot feedback is sampled in SPAWN for spawning and in REMOVE for retiring. Slots have had the SETTLE cycle to register their update.
- Tick-to-RUN latency = 3 + k cycles, where k = number retired (k ≤ `SLOTS`).
- A tick while `busy` is dropped and sets `overrun`. `overrun` clears only on reset.
- Simultaneous `crash` and `tick` in RUN: crash wins, no `slot_update`.
- Crash mid-REMOVE: slots already retired stay retired; the rest freeze.
- `rst_n` low mid-sequence: immediate clear; `slot_start` drops asynchronously.

## Structure
- `spawn_pkg`: `state_t`, NONE=0, default `GAME_WIDTH`.
- Combinational sub-module `spawn_type_picker`: inputs `rng`, `speed`, `min_speed`, newest-`MAX_DUP` types plus valid bits; outputs type and valid.
- Rest: FSM, ring pointers, slot register arrays.

## Test plan
- Empty ring, `enable`=1, `rng`=0, all `min_speed`=0, `tick` → cycle+1 `slot_update`=1; `slot_start[0]`=1, `slot_type[0]`=1, `count`=1; RUN 3 cycles after `tick`.
- Last slot at x=500, width 50, gap 100 (650 ≥ 640) → no spawn. Set x=480 (630) → spawn into the next slot.
- Newest two slots type 2, `rng`=1 → candidate 2 rejected, type 3 spawned. Raise `min_speed[3]` above `speed` → type 1.
- `SLOTS`=7 full, spawn due → `full_drop` one-cycle pulse, `count` stays 7. Wrap: `front`=6 retires → `front`=0.
- Slots 0–2 `slot_remove`=1 → three REMOVE cycles, `count` drops by 3, RUN 6 cycles after `tick`.
- `crash` with `tick` in RUN → CRASHED, no `slot_update`. Later ticks ignored. `rst_n` low → all outputs 0 within the same cycle.

Source files
------------

// File: rtl/spawn_pkg.sv
// spawn_pkg: shared FSM encoding and defaults for the per-class spawn scheduler.
package spawn_pkg;
    typedef enum logic [2:0] {WAIT, RUN, SPAWN, SETTLE, REMOVE, CRASHED} state_t;
    localparam int NONE = 0;
    localparam int GAME_WIDTH_DEFAULT = 640;
endpackage

// File: rtl/spawn_type_picker.sv
// spawn_type_picker: picks the first rng-rotated type that meets its minimum speed
// and would not exceed the consecutive-duplicate limit.
module spawn_type_picker import spawn_pkg::*; #(
    parameter int TYPE_COUNT = 3,
    parameter int TYPE_W     = 3,
    parameter int MAX_DUP    = 2
) (
    input  logic [10:0]       rng,
    input  logic [14:0]       speed,
    input  logic [14:0]       min_speed [TYPE_COUNT+1],
    input  logic [TYPE_W-1:0] recent_type [MAX_DUP],
    input  logic              recent_valid [MAX_DUP],
    output logic [TYPE_W-1:0] pick_type,
    output logic              pick_valid
);
    logic [TYPE_W-1:0] cand;
    logic [14:0]       ms;
    logic              dup;

    always_comb begin
        pick_type  = TYPE_W'(NONE);
        pick_valid = 1'b0;
        cand       = '0;
        ms         = '0;
        dup        = 1'b0;
        for (int i = 0; i < TYPE_COUNT; i++) begin
            cand = TYPE_W'((int'(rng) + i) % TYPE_COUNT + 1);
            ms   = '0;
            for (int t = 0; t <= TYPE_COUNT; t++)
                if (cand == TYPE_W'(t)) ms = min_speed[t];
            // an invalid entry means the ring holds fewer than MAX_DUP, so no limit
            dup = 1'b1;
            for (int j = 0; j < MAX_DUP; j++)
                dup = dup && recent_valid[j] && (recent_type[j] == cand);
            if (!pick_valid && speed >= ms && !dup) begin
                pick_type  = cand;
                pick_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: ring of entity slots for one scrolling class; per frame tick it
// spawns at the back when there is room on screen, then retires expired entries at the front.
module spawn_scheduler import spawn_pkg::*; #(
    parameter int SLOTS      = 7,
    parameter int IDX_W      = $clog2(SLOTS),
    parameter int TYPE_COUNT = 3,
    parameter int TYPE_W     = 3,
    parameter int MAX_DUP    = 2,
    parameter int GAME_WIDTH = GAME_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                crash,
    input  logic                tick,
    input  logic                enable,
    input  logic [10:0]         rng,
    input  logic [14:0]         speed,
    input  logic [14:0]         min_speed [TYPE_COUNT+1],
    input  logic signed [10:0]  slot_x [SLOTS],
    input  logic [9:0]          slot_width [SLOTS],
    input  logic [10:0]         slot_gap [SLOTS],
    input  logic                slot_visible [SLOTS],
    input  logic                slot_remove [SLOTS],
    output logic                slot_start [SLOTS],
    output logic [TYPE_W-1:0]   slot_type [SLOTS],
    output logic                slot_update,
    output logic [IDX_W-1:0]    front,
    output logic [IDX_W:0]      count,
    output logic                busy,
    output logic                overrun,
    output logic                full_drop
);
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   front_q, front_d, last, back;
    logic [IDX_W:0]     count_q, count_d;
    logic               start_q [SLOTS];
    logic               start_d [SLOTS];
    logic [TYPE_W-1:0]  type_q [SLOTS];
    logic [TYPE_W-1:0]  type_d [SLOTS];
    logic               overrun_q, overrun_d;
    logic [TYPE_W-1:0]  recent_type [MAX_DUP];
    logic               recent_valid [MAX_DUP];
    logic [TYPE_W-1:0]  pick_type;
    logic               pick_valid;
    logic signed [12:0] reach;
    logic               due, full;

    spawn_type_picker #(.TYPE_COUNT(TYPE_COUNT), .TYPE_W(TYPE_W), .MAX_DUP(MAX_DUP)) u_picker (
        .rng(rng), .speed(speed), .min_speed(min_speed),
        .recent_type(recent_type), .recent_valid(recent_valid),
        .pick_type(pick_type), .pick_valid(pick_valid)
    );

    always_comb begin
        last  = IDX_W'((int'(front_q) + int'(count_q) + SLOTS - 1) % SLOTS);
        back  = IDX_W'((int'(front_q) + int'(count_q)) % SLOTS);
        for (int j = 0; j < MAX_DUP; j++) begin
            recent_type[j]  = type_q[IDX_W'((int'(front_q) + int'(count_q) + SLOTS - 1 - j) % SLOTS)];
            recent_valid[j] = int'(count_q) > j;
        end
        reach = {{2{slot_x[last][10]}}, slot_x[last]} + {3'b000, slot_width[last]} + {2'b00, slot_gap[last]};
        full  = count_q == (IDX_W+1)'(SLOTS);
        due   = enable && (count_q == '0 || (slot_visible[last] && reach < 13'(GAME_WIDTH)));
    end

    always_comb begin
        state_d   = state_q;
        front_d   = front_q;
        count_d   = count_q;
        start_d   = start_q;
        type_d    = type_q;
        overrun_d = overrun_q | (tick & busy);
        case (state_q)
            WAIT:   if (start) state_d = RUN;
            RUN:    if (tick) state_d = SPAWN;
            SPAWN: begin
                state_d = SETTLE;
                if (due && !full && pick_valid) begin
                    start_d[back] = 1'b1;
                    type_d[back]  = pick_type;
                    count_d       = count_q + 1'b1;
                end
            end
            SETTLE: state_d = REMOVE;
            REMOVE: begin
                if (count_q != '0 && slot_remove[front_q]) begin
                    start_d[front_q] = 1'b0;
                    type_d[front_q]  = TYPE_W'(NONE);
                    front_d          = (front_q == IDX_W'(SLOTS - 1)) ? '0 : front_q + 1'b1;
                    count_d          = count_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: ;
        endcase
        // a crash freezes the ring exactly as it stands, so pending writes are dropped
        if (crash && state_q != WAIT) begin
            state_d = CRASHED;
            front_d = front_q;
            count_d = count_q;
            start_d = start_q;
            type_d  = type_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT;
            front_q   <= '0;
            count_q   <= '0;
            start_q   <= '{default: 1'b0};
            type_q    <= '{default: '0};
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            front_q   <= front_d;
            count_q   <= count_d;
            start_q   <= start_d;
            type_q    <= type_d;
            overrun_q <= overrun_d;
        end
    end

    assign slot_start  = start_q;
    assign slot_type   = type_q;
    assign slot_update = state_q == SPAWN;
    assign front       = front_q;
    assign count       = count_q;
    assign busy        = state_q inside {SPAWN, SETTLE, REMOVE};
    assign overrun     = overrun_q;
    assign full_drop   = (state_q == SPAWN) && due && full;
endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: directed vectors for spawn_scheduler with hand-computed ring contents.
module tb_spawn_scheduler;
    logic               clk = 1'b0;
    logic               rst_n, start, crash, tick, enable;
    logic [10:0]        rng;
    logic [14:0]        speed;
    logic [14:0]        min_speed [4];
    logic signed [10:0] slot_x [7];
    logic [9:0]         slot_width [7];
    logic [10:0]        slot_gap [7];
    logic               slot_visible [7];
    logic               slot_remove [7];
    logic               slot_start [7];
    logic [2:0]         slot_type [7];
    logic               slot_update;
    logic [2:0]         front;
    logic [3:0]         count;
    logic               busy, overrun, full_drop;

    int tests = 0, fails = 0;
    int lat, upd_cnt, drop_cnt, upd_first;

    spawn_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .crash(crash), .tick(tick), .enable(enable),
        .rng(rng), .speed(speed), .min_speed(min_speed),
        .slot_x(slot_x), .slot_width(slot_width), .slot_gap(slot_gap),
        .slot_visible(slot_visible), .slot_remove(slot_remove),
        .slot_start(slot_start), .slot_type(slot_type), .slot_update(slot_update),
        .front(front), .count(count), .busy(busy), .overrun(overrun), .full_drop(full_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_tick(input bit extra);
        int n;
        n = 0;
        upd_cnt = 0;
        drop_cnt = 0;
        upd_first = 0;
        @(negedge clk);
        tick = 1'b1;
        do begin
            @(negedge clk);
            n++;
            tick = extra && n == 1;
            if (slot_update) upd_cnt++;
            if (n == 1) upd_first = int'(slot_update);
            if (full_drop) drop_cnt++;
        end while (busy && n < 40);
        lat = n - 1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; crash = 1'b0; tick = 1'b0; enable = 1'b1;
        rng = '0; speed = 15'd100;
        for (int i = 0; i < 4; i++) min_speed[i] = '0;
        for (int i = 0; i < 7; i++) begin
            slot_x[i] = 11'sd480; slot_width[i] = 10'd50; slot_gap[i] = 11'd100;
            slot_visible[i] = 1'b1; slot_remove[i] = 1'b0;
        end
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_front", front, 0);
        check("rst_update", slot_update, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_start0", slot_start[0], 0);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        do_tick(1'b0);
        check("t1_update_next", upd_first, 1);
        check("t1_update_once", upd_cnt, 1);
        check("t1_latency", lat, 3);
        check("t1_start0", slot_start[0], 1);
        check("t1_type0", slot_type[0], 1);
        check("t1_count", count, 1);

        slot_x[0] = 11'sd500;
        do_tick(1'b0);
        check("t2_nospawn_count", count, 1);
        check("t2_nospawn_start1", slot_start[1], 0);

        slot_x[0] = 11'sd480;
        do_tick(1'b0);
        check("t3_count", count, 2);
        check("t3_type1", slot_type[1], 1);

        do_tick(1'b0);
        check("t4_dup_type2", slot_type[2], 2);

        rng = 11'd1;
        do_tick(1'b0);
        check("t5_type3slot", slot_type[3], 2);

        do_tick(1'b0);
        check("t6_dup_skip_to3", slot_type[4], 3);
        do_tick(1'b0);
        check("t7_type5", slot_type[5], 2);
        do_tick(1'b0);
        check("t8_type6", slot_type[6], 2);
        check("t8_count_full", count, 7);

        do_tick(1'b0);
        check("t9_full_drop", drop_cnt, 1);
        check("t9_count", count, 7);
        check("t9_latency", lat, 3);

        for (int i = 0; i < 3; i++) slot_remove[i] = 1'b1;
        do_tick(1'b0);
        check("t10_full_drop", drop_cnt, 1);
        check("t10_count", count, 4);
        check("t10_front", front, 3);
        check("t10_latency", lat, 6);
        check("t10_start0", slot_start[0], 0);
        for (int i = 0; i < 3; i++) slot_remove[i] = 1'b0;

        min_speed[3] = 15'd200;
        do_tick(1'b0);
        check("t11_speed_skip_to1", slot_type[0], 1);
        check("t11_count", count, 5);

        for (int i = 3; i < 7; i++) slot_remove[i] = 1'b1;
        do_tick(1'b0);
        check("t12_type1", slot_type[1], 2);
        check("t12_wrap_front", front, 0);
        check("t12_count", count, 2);
        check("t12_latency", lat, 7);
        check("t12_start6", slot_start[6], 0);
        check("t12_type6", slot_type[6], 0);
        for (int i = 3; i < 7; i++) slot_remove[i] = 1'b0;

        do_tick(1'b1);
        check("t13_overrun", overrun, 1);
        check("t13_update_once", upd_cnt, 1);
        check("t13_count", count, 3);
        check("t13_type2", slot_type[2], 2);

        @(negedge clk);
        tick = 1'b1; crash = 1'b1;
        @(negedge clk);
        tick = 1'b0; crash = 1'b0;
        check("crash_no_update", slot_update, 0);
        check("crash_not_busy", busy, 0);
        upd_cnt = 0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (slot_update) upd_cnt++;
        end
        check("crash_tick_ignored", upd_cnt, 0);
        check("crash_count_frozen", count, 3);
        check("crash_overrun_kept", overrun, 1);

        #2 rst_n = 1'b0;
        #1;
        check("async_rst_start0", slot_start[0], 0);
        check("async_rst_count", count, 0);
        check("async_rst_type1", slot_type[1], 0);
        check("async_rst_overrun", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
